pc_sequencer: RTL and testbench

- Control FSM that sequences the single-cycle CPU's ProgramCounter through reset-vector load, fetch, execute-wait and PC-update.
- Sole driver of pcWriteEnable, pcWriteData and pcOp. Reads pcReadData back.
- Arbitrates PC sources with fixed priority: trap, mret, branch/jump redirect, sequential.
- Handshakes with instruction memory (req/ack), with a fetch timeout that raises a fetch-fault trap.

---
 rtl/pc_sequencer_pkg.sv | 28 ++
 rtl/pc_fetch_timer.sv | 29 ++
 rtl/pc_sequencer.sv | 168 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: PC op codes, FSM states, trap causes.
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        PC_SEQ  = 3'd0,
        PC_JUMP = 3'd2
    } pcOpT;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_TRAP  = 2'd3
    } seqStateT;

    typedef enum logic [3:0] {
        CAUSE_NONE          = 4'd0,
        CAUSE_FETCH_TIMEOUT = 4'd1,
        CAUSE_EXEC_TRAP     = 4'd2,
        CAUSE_MISALIGNED    = 4'd3
    } trapCauseT;

    // A PC target is misaligned when it is not on a 32-bit word boundary.
    function automatic logic isMisaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_timer.sv
// Fetch wait counter: 8-bit up-counter with clear (priority) and enable,
// flagging when the count equals the terminal value.
module pc_fetch_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] terminal,
    output logic       terminalCount
);

    logic [7:0] count_r;

    // Count FETCH cycles; clear wins over enable, reset wins over both.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 8'd0;
        end else if (clear) begin
            count_r <= 8'd0;
        end else if (enable) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign terminalCount = (count_r == terminal);

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: drives the ProgramCounter through reset-vector load, fetch,
// execute-wait and PC update, with trap / mret / redirect / sequential
// priority and a fetch timeout that raises a fetch-fault trap.
// Optional build macro PC_SEQUENCER_MISALIGN_CHECK_EN turns misaligned
// redirect or mret targets into traps with cause 3.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR   = 32'h0000_0100,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcReadData,
    output logic        pcWriteEnable,
    output logic [31:0] pcWriteData,
    output logic [2:0]  pcOp,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        trap_req,
    input  logic        mret,
    output logic [31:0] epc,
    output logic [3:0]  cause,
    output logic [1:0]  state
);

    localparam logic [7:0] TIMER_TERMINAL = 8'(FETCH_TIMEOUT - 1);

    seqStateT    state_r;
    seqStateT    stateNext_s;
    logic [31:0] epc_r;
    logic [31:0] epcNext_s;
    logic [3:0]  cause_r;
    logic [3:0]  causeNext_s;
    logic        timerClear_s;
    logic        timerEnable_s;
    logic        timerDone_s;
    logic        misalignTrap_s;

    pc_fetch_timer uFetchTimer (
        .clk           (clk),
        .reset         (reset),
        .clear         (timerClear_s),
        .enable        (timerEnable_s),
        .terminal      (TIMER_TERMINAL),
        .terminalCount (timerDone_s)
    );

`ifdef PC_SEQUENCER_MISALIGN_CHECK_EN
    // Flag a misaligned target for whichever of mret / redirect would be taken.
    always_comb begin
        if (mret) begin
            misalignTrap_s = isMisaligned(epc_r);
        end else if (redirect) begin
            misalignTrap_s = isMisaligned(redirect_target);
        end else begin
            misalignTrap_s = 1'b0;
        end
    end
`else
    assign misalignTrap_s = 1'b0;
`endif

    // State, saved PC and trap cause registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_RST;
            epc_r   <= 32'h0000_0000;
            cause_r <= CAUSE_NONE;
        end else begin
            state_r <= stateNext_s;
            epc_r   <= epcNext_s;
            cause_r <= causeNext_s;
        end
    end

    // Next-state, trap bookkeeping and combinational PC / fetch controls.
    always_comb begin
        stateNext_s   = state_r;
        epcNext_s     = epc_r;
        causeNext_s   = cause_r;
        pcWriteEnable = 1'b0;
        pcWriteData   = 32'h0000_0000;
        pcOp          = PC_SEQ;
        imem_req      = 1'b0;
        instr_valid   = 1'b0;
        timerEnable_s = 1'b0;
        timerClear_s  = 1'b1;
        if (reset) begin
            // Everything idles while reset is held; registers clear in the flop block.
            stateNext_s = ST_RST;
        end else begin
            case (state_r)
                ST_RST: begin
                    pcWriteEnable = 1'b1;
                    pcOp          = PC_JUMP;
                    pcWriteData   = RESET_VECTOR;
                    stateNext_s   = ST_FETCH;
                end
                ST_FETCH: begin
                    imem_req      = 1'b1;
                    timerEnable_s = 1'b1;
                    timerClear_s  = 1'b0;
                    if (imem_ack) begin
                        // Ack wins over a simultaneous timeout.
                        instr_valid  = 1'b1;
                        timerClear_s = 1'b1;
                        stateNext_s  = ST_EXEC;
                    end else if (timerDone_s) begin
                        epcNext_s    = pcReadData;
                        causeNext_s  = CAUSE_FETCH_TIMEOUT;
                        timerClear_s = 1'b1;
                        stateNext_s  = ST_TRAP;
                    end else begin
                        stateNext_s = ST_FETCH;
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        pcWriteEnable = 1'b1;
                        stateNext_s   = ST_FETCH;
                        if (trap_req) begin
                            epcNext_s   = pcReadData;
                            causeNext_s = CAUSE_EXEC_TRAP;
                            pcOp        = PC_JUMP;
                            pcWriteData = TRAP_VECTOR;
                        end else if (misalignTrap_s) begin
                            epcNext_s   = pcReadData;
                            causeNext_s = CAUSE_MISALIGNED;
                            pcOp        = PC_JUMP;
                            pcWriteData = TRAP_VECTOR;
                        end else if (mret) begin
                            causeNext_s = CAUSE_NONE;
                            pcOp        = PC_JUMP;
                            pcWriteData = epc_r;
                        end else if (redirect) begin
                            pcOp        = PC_JUMP;
                            pcWriteData = redirect_target;
                        end else begin
                            pcOp = PC_SEQ;
                        end
                    end else begin
                        stateNext_s = ST_EXEC;
                    end
                end
                ST_TRAP: begin
                    pcWriteEnable = 1'b1;
                    pcOp          = PC_JUMP;
                    pcWriteData   = TRAP_VECTOR;
                    stateNext_s   = ST_FETCH;
                end
                default: begin
                    stateNext_s = ST_RST;
                end
            endcase
        end
    end

    assign epc   = epc_r;
    assign cause = cause_r;
    assign state = state_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: transaction-level reference model of the PC
// flow (expected PC, epc, cause) with randomized fetch latency, exec latency,
// ignored noise inputs and redirect/trap/mret mixes.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_VEC     = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC      = 32'h0000_0100;
    localparam int          FETCH_TIMEOUT = 16;
`ifdef PC_SEQUENCER_MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pcReadData;
    logic        pcWriteEnable;
    logic [31:0] pcWriteData;
    logic [2:0]  pcOp;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic        instr_valid;
    logic        exec_done = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        trap_req = 1'b0;
    logic        mret = 1'b0;
    logic [31:0] epc;
    logic [3:0]  cause;
    logic [1:0]  state;

    logic [31:0] pcReg = 32'h0;
    logic [31:0] expPc = 32'h0;
    logic [31:0] expEpc = 32'h0;
    logic [3:0]  expCause = 4'd0;
    int          checks = 0;
    int          passes = 0;

    pc_sequencer #(
        .RESET_VECTOR  (RESET_VEC),
        .TRAP_VECTOR   (TRAP_VEC),
        .FETCH_TIMEOUT (FETCH_TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pcReadData      (pcReadData),
        .pcWriteEnable   (pcWriteEnable),
        .pcWriteData     (pcWriteData),
        .pcOp            (pcOp),
        .imem_req        (imem_req),
        .imem_ack        (imem_ack),
        .instr_valid     (instr_valid),
        .exec_done       (exec_done),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .trap_req        (trap_req),
        .mret            (mret),
        .epc             (epc),
        .cause           (cause),
        .state           (state)
    );

    always #5 clk = ~clk;

    // External ProgramCounter: applies the strobed op at the rising edge.
    always @(posedge clk) begin
        if (pcWriteEnable) begin
            if (pcOp == 3'd2) pcReg <= pcWriteData;
            else              pcReg <= pcReg + 32'd4;
        end
    end
    assign pcReadData = pcReg;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Hold reset for a few cycles, release it and expect the reset-vector load.
    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            imem_ack = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({state, epc, cause, pcWriteEnable, pcOp, pcWriteData, imem_req, instr_valid}
                !== {2'd0, 32'd0, 4'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0})
                $display("FAIL reset_idle: got st=%0d epc=%h cause=%0d we=%b op=%0d wd=%h req=%b iv=%b expected all zero",
                         state, epc, cause, pcWriteEnable, pcOp, pcWriteData, imem_req, instr_valid);
            else passes++;
        end
        @(negedge clk);
        reset = 1'b0;
        imem_ack = 1'b0;
        #1;
        checks++;
        if ({state, pcWriteEnable, pcOp, pcWriteData, imem_req} !== {2'd0, 1'b1, 3'd2, RESET_VEC, 1'b0})
            $display("FAIL reset_release: got st=%0d we=%b op=%0d wd=%h req=%b expected st=0 we=1 op=2 wd=%h req=0",
                     state, pcWriteEnable, pcOp, pcWriteData, imem_req, RESET_VEC);
        else passes++;
        expPc = RESET_VEC;
        expEpc = 32'h0;
        expCause = 4'd0;
    endtask

    // One fetch: ack after waitCycles FETCH cycles, or timeout if never acked.
    task automatic do_fetch(input int waitCycles, output bit timedOut);
        bit acked;
        acked = 1'b0;
        for (int k = 0; k < FETCH_TIMEOUT && !acked; k++) begin
            @(negedge clk);
            exec_done = 1'b0; trap_req = 1'b0; mret = 1'b0; redirect = 1'b0;
            imem_ack = (k == waitCycles);
            #1;
            if (k == 0) begin
                checks++;
                if ({pcReadData, epc, cause} !== {expPc, expEpc, expCause})
                    $display("FAIL fetch_entry: got pc=%h epc=%h cause=%0d expected pc=%h epc=%h cause=%0d",
                             pcReadData, epc, cause, expPc, expEpc, expCause);
                else passes++;
            end
            checks++;
            if ({state, imem_req, instr_valid, pcWriteEnable, pcWriteData} !== {2'd1, 1'b1, imem_ack, 1'b0, 32'd0})
                $display("FAIL fetch_cycle%0d: got st=%0d req=%b iv=%b we=%b wd=%h expected st=1 req=1 iv=%b we=0 wd=0",
                         k, state, imem_req, instr_valid, pcWriteEnable, pcWriteData, imem_ack);
            else passes++;
            acked = imem_ack;
        end
        timedOut = !acked;
        if (!acked) begin
            @(negedge clk);
            imem_ack = 1'($urandom_range(0, 1));
            #1;
            expEpc = expPc;
            expCause = 4'd1;
            checks++;
            if ({state, epc, cause, pcWriteEnable, pcOp, pcWriteData, imem_req, instr_valid}
                !== {2'd3, expEpc, expCause, 1'b1, 3'd2, TRAP_VEC, 1'b0, 1'b0})
                $display("FAIL fetch_timeout_trap: got st=%0d epc=%h cause=%0d we=%b op=%0d wd=%h req=%b iv=%b expected st=3 epc=%h cause=1 we=1 op=2 wd=%h req=0 iv=0",
                         state, epc, cause, pcWriteEnable, pcOp, pcWriteData, imem_req, instr_valid, expEpc, TRAP_VEC);
            else passes++;
            expPc = TRAP_VEC;
        end
    endtask

    // One execute phase: idle cycles with ignored noise, then exec_done with the given flags.
    task automatic do_exec(input int idle, input bit tr, input bit mr, input bit rd, input logic [31:0] tgt);
        logic [2:0]  expOp;
        logic [31:0] expData;
        for (int i = 0; i < idle; i++) begin
            @(negedge clk);
            exec_done = 1'b0;
            imem_ack = 1'($urandom_range(0, 1));
            trap_req = 1'($urandom_range(0, 1));
            mret = 1'($urandom_range(0, 1));
            redirect = 1'($urandom_range(0, 1));
            redirect_target = $urandom;
            #1;
            checks++;
            if ({state, imem_req, instr_valid, pcWriteEnable, pcWriteData} !== {2'd2, 1'b0, 1'b0, 1'b0, 32'd0})
                $display("FAIL exec_wait: got st=%0d req=%b iv=%b we=%b wd=%h expected st=2 req=0 iv=0 we=0 wd=0",
                         state, imem_req, instr_valid, pcWriteEnable, pcWriteData);
            else passes++;
        end
        @(negedge clk);
        imem_ack = 1'($urandom_range(0, 1));
        exec_done = 1'b1; trap_req = tr; mret = mr; redirect = rd; redirect_target = tgt;
        #1;
        expOp = 3'd2;
        if (tr) begin
            expData = TRAP_VEC; expEpc = expPc; expCause = 4'd2;
        end else if (mr && !(MIS && expEpc[1:0] != 2'b00)) begin
            expData = expEpc; expCause = 4'd0;
        end else if (!mr && rd && !(MIS && tgt[1:0] != 2'b00)) begin
            expData = tgt;
        end else if (mr || rd) begin
            expData = TRAP_VEC; expEpc = expPc; expCause = 4'd3;
        end else begin
            expOp = 3'd0; expData = 32'd0;
        end
        checks++;
        if ({state, pcWriteEnable, pcOp, pcWriteData, instr_valid} !== {2'd2, 1'b1, expOp, expData, 1'b0})
            $display("FAIL exec_done(tr=%b mr=%b rd=%b tgt=%h): got st=%0d we=%b op=%0d wd=%h iv=%b expected st=2 we=1 op=%0d wd=%h iv=0",
                     tr, mr, rd, tgt, state, pcWriteEnable, pcOp, pcWriteData, instr_valid, expOp, expData);
        else passes++;
        expPc = (expOp == 3'd2) ? expData : expPc + 32'd4;
    endtask

    task automatic test_sequential();
        bit to;
        do_fetch(2, to);
        do_exec(1, 1'b0, 1'b0, 1'b0, 32'h0);
        do_fetch(0, to);
        do_exec(0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_redirect_and_trap();
        bit to;
        do_fetch(1, to);
        do_exec(0, 1'b0, 1'b0, 1'b1, 32'h40);
        do_fetch(0, to);
        do_exec(2, 1'b0, 1'b0, 1'b1, 32'h8);
        do_fetch(3, to);
        do_exec(0, 1'b1, 1'b0, 1'b1, 32'h40);
    endtask

    task automatic test_mret();
        bit to;
        do_fetch(0, to);
        do_exec(2, 1'b0, 1'b1, 1'b1, 32'h200);
        do_fetch(0, to);
        do_exec(0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_timeout();
        bit to;
        do_fetch(FETCH_TIMEOUT - 1, to);
        checks++;
        if (to !== 1'b0) $display("FAIL ack_on_last_cycle: got timeout=%b expected 0", to);
        else passes++;
        do_exec(0, 1'b0, 1'b0, 1'b0, 32'h0);
        do_fetch(FETCH_TIMEOUT, to);
        checks++;
        if (to !== 1'b1) $display("FAIL withheld_ack: got timeout=%b expected 1", to);
        else passes++;
        do_fetch(0, to);
        do_exec(1, 1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_misalign();
        bit to;
        do_fetch(0, to);
        do_exec(0, 1'b0, 1'b0, 1'b1, 32'h42);
        do_fetch(1, to);
        do_exec(0, 1'b1, 1'b0, 1'b1, 32'h43);
        do_fetch(0, to);
        do_exec(0, 1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        #1;
        checks++;
        if (state !== 2'd1) $display("FAIL mid_reset_pre: got st=%0d expected 1", state);
        else passes++;
        @(negedge clk);
        reset = 1'b1;
        imem_ack = 1'b1;
        #1;
        checks++;
        if ({pcWriteEnable, pcOp, pcWriteData, imem_req, instr_valid} !== {1'b0, 3'd0, 32'd0, 1'b0, 1'b0})
            $display("FAIL mid_reset_outputs: got we=%b op=%0d wd=%h req=%b iv=%b expected all zero",
                     pcWriteEnable, pcOp, pcWriteData, imem_req, instr_valid);
        else passes++;
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        checks++;
        if ({state, epc, cause, pcWriteEnable, imem_req} !== {2'd0, 32'd0, 4'd0, 1'b0, 1'b0})
            $display("FAIL mid_reset_state: got st=%0d epc=%h cause=%0d we=%b req=%b expected 0",
                     state, epc, cause, pcWriteEnable, imem_req);
        else passes++;
        test_reset();
    endtask

    task automatic test_random();
        bit          to;
        logic [31:0] tgt;
        int          sel;
        for (int n = 0; n < 40; n++) begin
            do_fetch($urandom_range(0, FETCH_TIMEOUT + 2), to);
            if (to) do_fetch($urandom_range(0, 4), to);
            if (to) continue;
            tgt = $urandom & 32'h0000_0FFC;
            if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            sel = $urandom_range(0, 9);
            do_exec($urandom_range(0, 3), sel == 0, sel == 1 || sel == 2,
                    sel >= 2 && sel <= 5, tgt);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect_and_trap();
        test_mret();
        test_timeout();
        test_misalign();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
